// File: rtl/fifo_burst_reader.sv
// Burst read controller: pops burst_len words from a synchronous FIFO and
// re-presents them on a valid/ready stream through a 2-entry skid buffer.
module fifo_burst_reader #(
    parameter int WIDTH = 8,
    parameter int LENW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LENW-1:0]  burst_len,
    output logic             busy,
    output logic             done,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [LENW-1:0]  rem_q, rem_d;

    logic [WIDTH-1:0] data_q [2];
    logic [1:0]       last_q;
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       occ_q, occ_d;

    logic             push, pop;

    assign push    = fifo_rd_en;
    assign pop     = m_valid & m_ready;
    assign m_valid = (occ_q != 2'd0);
    assign m_data  = data_q[rd_ptr_q];
    assign m_last  = last_q[rd_ptr_q];
    assign busy    = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done    = (state_q == S_DONE);

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        fifo_rd_en = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        rem_d   = burst_len;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                // Gated on buffer room only, never on m_ready, to keep the FIFO path short.
                fifo_rd_en = !fifo_empty && (rem_q != '0) && (occ_q != 2'd2);
                if (fifo_rd_en) begin
                    rem_d = rem_q - LENW'(1);
                    if (rem_q == LENW'(1)) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (pop && m_last) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        occ_d = occ_q;
        if (push && !pop)      occ_d = occ_q + 2'd1;
        else if (!push && pop) occ_d = occ_q - 2'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // NOTE: the two buffer entries are reset too, so m_data reads zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) data_q[i] <= '0;
            last_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr_q] <= fifo_dout;
                last_q[wr_ptr_q] <= (rem_q == LENW'(1));
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_d;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized self-checking bench for fifo_burst_reader: a queue-based FIFO and
// stream scoreboard predict every output cycle by cycle.
module tb_fifo_burst_reader;

    localparam int WIDTH = 8;
    localparam int LENW  = 8;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LENW-1:0]  burst_len = '0;
    logic             busy, done;
    logic             fifo_empty = 1'b1;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_dout = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } word_t;

    logic [WIDTH-1:0] fifo_q [$];
    word_t            mbuf [$];
    int               mstate = M_IDLE;
    logic [LENW-1:0]  rem = '0;
    logic [LENW-1:0]  cur_len = '0;
    int               obs_reads = 0;
    bit               auto_fill = 1'b0;
    bit               rnd_ready = 1'b0;
    int               checks = 0;
    int               errors = 0;

    fifo_burst_reader #(.WIDTH(WIDTH), .LENW(LENW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .burst_len  (burst_len),
        .busy       (busy),
        .done       (done),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mbuf.delete();
        mstate = M_IDLE;
        rem    = '0;
    endtask

    // One clock cycle: present FIFO state, check outputs at the falling edge,
    // then advance the reference model across the rising edge.
    task automatic tick();
        logic  exp_rd, exp_valid, pop;
        word_t w;
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? '0 : fifo_q[0];
        @(negedge clk);
        if (!rst_n) model_reset();
        exp_valid = (mbuf.size() != 0);
        exp_rd    = (mstate == M_RUN) && !fifo_empty && (rem != 0) && (mbuf.size() < 2);
        check("busy",    32'(busy),       32'(mstate == M_RUN));
        check("done",    32'(done),       32'(mstate == M_DONE));
        check("rd_en",   32'(fifo_rd_en), 32'(exp_rd));
        check("m_valid", 32'(m_valid),    32'(exp_valid));
        if (exp_valid) begin
            check("m_data", 32'(m_data), 32'(mbuf[0].data));
            check("m_last", 32'(m_last), 32'(mbuf[0].last));
        end
        if (fifo_rd_en === 1'b1) obs_reads++;
        pop = exp_valid && m_ready;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            case (mstate)
                M_DONE: mstate = M_IDLE;
                M_IDLE: begin
                    if (start) begin
                        obs_reads = 0;
                        if (burst_len == 0) begin
                            mstate = M_DONE;
                        end else begin
                            mstate  = M_RUN;
                            rem     = burst_len;
                            cur_len = burst_len;
                        end
                    end
                end
                default: begin
                    if (pop) begin
                        w = mbuf.pop_front();
                        if (w.last) begin
                            check("burst_reads", 32'(obs_reads), 32'(cur_len));
                            mstate = M_DONE;
                        end
                    end
                    if (exp_rd) begin
                        w.data = fifo_q.pop_front();
                        w.last = (rem == 1);
                        mbuf.push_back(w);
                        rem--;
                    end
                end
            endcase
        end
        if (auto_fill && fifo_q.size() < 12 && $urandom_range(0, 3) != 0)
            fifo_q.push_back(WIDTH'($urandom));
    endtask

    task automatic finish_burst(input int limit);
        int n = 0;
        while (mstate != M_IDLE && n < limit) begin
            m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        check("burst_finished", 32'(mstate == M_IDLE), 32'd1);
    endtask

    task automatic run_burst(input logic [LENW-1:0] len, input int limit);
        start     = 1'b1;
        burst_len = len;
        m_ready   = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        tick();
        start     = 1'b0;
        burst_len = LENW'($urandom);
        finish_burst(limit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with start asserted and data waiting in the FIFO.
        fifo_q    = '{8'hA0, 8'hA1};
        start     = 1'b1;
        burst_len = 8'd3;
        m_ready   = 1'b1;
        repeat (3) tick();
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (2) tick();
        check("rst_no_reads", 32'(obs_reads), 32'd0);

        // Streaming burst of three words.
        fifo_q = '{8'h11, 8'h22, 8'h33};
        run_burst(8'd3, 50);
        check("stream_reads", 32'(obs_reads), 32'd3);

        // Backpressure: only two reads while the consumer stalls.
        fifo_q    = '{8'h41, 8'h42, 8'h43, 8'h44};
        start     = 1'b1;
        burst_len = 8'd4;
        m_ready   = 1'b0;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("bp_reads_stalled", 32'(obs_reads), 32'd2);
        check("bp_data_frozen",   32'(m_data),    32'h41);
        finish_burst(50);

        // Underrun: one word available for a three-word burst.
        fifo_q    = '{8'h51};
        start     = 1'b1;
        burst_len = 8'd3;
        m_ready   = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("underrun_reads", 32'(obs_reads), 32'd1);
        check("underrun_busy",  32'(busy),      32'd1);
        fifo_q.push_back(8'h52);
        fifo_q.push_back(8'h53);
        finish_burst(50);

        // Zero-length burst must not touch the FIFO.
        fifo_q = '{8'h61, 8'h62};
        run_burst(8'd0, 10);
        check("zero_len_reads", 32'(obs_reads), 32'd0);

        // A start pulse mid-burst is ignored.
        fifo_q    = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h75};
        start     = 1'b1;
        burst_len = 8'd5;
        tick();
        start = 1'b0;
        tick();
        start     = 1'b1;
        burst_len = 8'd9;
        tick();
        start = 1'b0;
        finish_burst(50);
        check("busy_start_reads", 32'(obs_reads), 32'd5);

        // Asynchronous reset after two of five words.
        fifo_q    = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85};
        start     = 1'b1;
        burst_len = 8'd5;
        m_ready   = 1'b0;
        tick();
        start = 1'b0;
        repeat (2) tick();
        check("mid_reads", 32'(obs_reads), 32'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        check("mid_rst_busy",  32'(busy),    32'd0);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_burst(8'd2, 50);
        check("post_rst_reads", 32'(obs_reads), 32'd2);

        // Randomized bursts with a trickling FIFO and a random consumer.
        fifo_q.delete();
        auto_fill = 1'b1;
        rnd_ready = 1'b1;
        for (int b = 0; b < 40; b++) begin
            logic [LENW-1:0] len;
            len = ($urandom_range(0, 9) == 0) ? LENW'($urandom_range(10, 40))
                                               : LENW'($urandom_range(0, 6));
            run_burst(len, 600);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
